led_pio_pwm: RTL and testbench
==============================

// Module: led_pio_pwm
// PURPOSE
//  Parametrised Avalon-MM LED output port replacing the fixed 8-bit single-register PIO.
//  Adds atomic set/clear access, per-channel blink with a programmable divider, and a global PWM dimmer.
//  Sits on a core's Avalon bus and drives board LEDs (green/red banks) directly.
//  With all registers at reset values it behaves as a plain write/readback output port.
// PARAMETERS
//  WIDTH          8    number of LED channels, 1..32
//  PWM_BITS       4    PWM counter/duty width, 1..16
//  DIV_BITS       24   blink divider width, 1..32
//  BLINK_DIV_RST  24'd4_999_999  reset value of BLINK_DIV
// PORTS
//  clk        in   1      system clock; the block's only clock
//  reset_n    in   1      reset, synchronous and active-low
//  address    in   3      word address of the register
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe
//  writedata  in   32     write data; bits above the register width are ignored
//  readdata   out  32     read data, zero-extended
//  out_port   out  WIDTH  LED drive, registered
// BEHAVIOUR
//  Write occurs when chipselect=1 and write_n=0 on a rising clk edge. Reads are combinational from address, with 0 wait states.
//  Register map (addr: name, access, reset):
//   0 DATA      RW    0              channel enables
//   1 SET       W1S   -              DATA |= wd; reads return DATA
//   2 CLR       W1C   -              DATA &= ~wd; reads return DATA
//   3 BLINK     RW    0              per-channel blink mask
//   4 DUTY      RW    all-ones       PWM duty, PWM_BITS wide
//   5 BLINK_DIV RW    BLINK_DIV_RST  divider terminal count
//   6,7 reserved: read 0, writes ignored.
//  Blink: div_cnt increments every cycle. When div_cnt==BLINK_DIV, div_cnt<=0 and phase toggles.
//   - BLINK_DIV=0: phase toggles every cycle.
//   - Full blink period is 2*(BLINK_DIV+1) cycles.
//   - A write to BLINK_DIV clears div_cnt and forces phase=1. This wins over a same-cycle terminal count (no toggle).
//  PWM: pwm_cnt is a free-running PWM_BITS counter that wraps from all-ones to 0.
//   - pwm_on = (DUTY==all-ones) | (pwm_cnt < DUTY).
//   - DUTY=0 means always off. All-ones means always on.
//  Output: out_port[i] <= DATA[i] & (~BLINK[i] | phase) & pwm_on. This is registered, so out_port follows
//   a register write 2 edges after the write edge: the register updates on the 1st edge, out_port on the 2nd.
//  Reset (reset_n=0 at an edge): registers take their reset values, div_cnt=0, pwm_cnt=0, phase=1, out_port=0.
//   Reset asserted mid-period aborts the count. The first blink toggle comes BLINK_DIV+1 cycles after release.
//  readdata = {zeros, reg} for the addressed register. It is valid whenever address is stable and does not depend on chipselect.
// STRUCTURE
//  Shared package (led_pio_pkg / include): register address localparams ADDR_DATA..ADDR_BLINK_DIV and the reserved-address rule.
//  One sub-module: led_blink_div (DIV_BITS counter with load/clear, terminal pulse, phase flop), instantiated once.
//  The PWM counter, register file and read mux stay in the top module.
// TESTING
//  1. Reset, then write DATA=0xA5 with DUTY at reset -> readdata(0)=0xA5; out_port=0xA5 2 edges after the write edge.
//  2. DATA=0xF0, write SET=0x0F, then CLR=0x81 -> DATA reads 0x7E after the two writes; reads of addr 1/2 also return 0x7E.
//  3. BLINK_DIV=3, BLINK=0x01, DATA=0x01 -> out_port[0] alternates 4 cycles on / 4 cycles off; bit 0 reads 0 from DATA? no: DATA unchanged.
//  4. PWM_BITS=4, DUTY=4, DATA=0xFF -> out_port=0xFF for 4 of every 16 cycles. DUTY=0 -> always 0. DUTY=15 -> always 0xFF.
//  5. Write BLINK_DIV on the cycle div_cnt hits the terminal count -> no toggle; phase=1; next toggle BLINK_DIV+1 cycles later.
//  6. Assert reset_n=0 mid-blink and mid-PWM for 1 cycle -> all registers at reset values, out_port=0 the next cycle; reserved addr 6 reads 0.

Source files
------------

// File: rtl/led_pio_pkg.sv
// Shared register map for the LED PIO/PWM port.
// Addresses 6 and 7 are reserved: they read as zero and ignore writes.
package led_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLR       = 3'd2;
  localparam logic [2:0] ADDR_BLINK     = 3'd3;
  localparam logic [2:0] ADDR_DUTY      = 3'd4;
  localparam logic [2:0] ADDR_BLINK_DIV = 3'd5;

  function automatic logic addr_reserved(input logic [2:0] a);
    return (a > ADDR_BLINK_DIV);
  endfunction

endpackage

// File: rtl/led_blink_div.sv
// Blink divider: counts to a terminal value, then toggles the blink phase.
// A clear (BLINK_DIV write) restarts the count and forces the phase on, beating a same-cycle terminal count.
module led_blink_div #(
  parameter int DIV_BITS = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_clr,
  input  logic [DIV_BITS-1:0] i_div,
  output logic                o_tc,
  output logic                o_phase
);

  logic [DIV_BITS-1:0] r_cnt;
  logic                r_phase;

  assign o_tc    = (r_cnt == i_div);
  assign o_phase = r_phase;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (o_tc) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pio_pwm.sv
// Avalon-MM LED output port: DATA with set/clear aliases, per-channel blink and a global PWM dimmer.
// With every register at reset it acts as a plain write/readback output port.
module led_pio_pwm
  import led_pio_pkg::*;
#(
  parameter int                  WIDTH         = 8,
  parameter int                  PWM_BITS      = 4,
  parameter int                  DIV_BITS      = 24,
  parameter logic [DIV_BITS-1:0] BLINK_DIV_RST = DIV_BITS'(4_999_999)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]    r_data;
  logic [WIDTH-1:0]    r_blink;
  logic [PWM_BITS-1:0] r_duty;
  logic [DIV_BITS-1:0] r_div;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [WIDTH-1:0]    r_out;

  logic                w_wr;
  logic                w_div_wr;
  logic                w_phase;
  logic                w_blink_tc;
  logic                w_pwm_on;
  logic [WIDTH-1:0]    w_wd;
  logic                w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_div_wr = w_wr & (address == ADDR_BLINK_DIV);
  assign w_wd     = writedata[WIDTH-1:0];
  assign w_pwm_on = (r_duty == {PWM_BITS{1'b1}}) | (r_pwm_cnt < r_duty);
  // Upper write-data bits and the terminal pulse are deliberately unused here.
  assign w_unused = ^{writedata, w_blink_tc};

  led_blink_div #(.DIV_BITS(DIV_BITS)) u_blink_div (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_div_wr),
    .i_div   (r_div),
    .o_tc    (w_blink_tc),
    .o_phase (w_phase)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data    <= '0;
      r_blink   <= '0;
      r_duty    <= '1;
      r_div     <= BLINK_DIV_RST;
      r_pwm_cnt <= '0;
      r_out     <= '0;
    end else begin
      if (w_wr) begin
        case (address)
          ADDR_DATA:      r_data  <= w_wd;
          ADDR_SET:       r_data  <= r_data | w_wd;
          ADDR_CLR:       r_data  <= r_data & ~w_wd;
          ADDR_BLINK:     r_blink <= w_wd;
          ADDR_DUTY:      r_duty  <= writedata[PWM_BITS-1:0];
          ADDR_BLINK_DIV: r_div   <= writedata[DIV_BITS-1:0];
          default: ;
        endcase
      end
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      // Output uses pre-write register values, so it lags a register write by one edge.
      r_out     <= r_data & (~r_blink | {WIDTH{w_phase}}) & {WIDTH{w_pwm_on}};
    end
  end

  assign out_port = r_out;

  always_comb begin
    readdata = '0;
    if (!addr_reserved(address)) begin
      case (address)
        ADDR_DATA, ADDR_SET, ADDR_CLR: readdata = 32'(r_data);
        ADDR_BLINK:                    readdata = 32'(r_blink);
        ADDR_DUTY:                     readdata = 32'(r_duty);
        ADDR_BLINK_DIV:                readdata = 32'(r_div);
        default:                       readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pio_pwm.sv
// Self-checking bench for led_pio_pwm: directed steps plus random traffic against a cycle-count model.
module tb_led_pio_pwm;

  localparam int W  = 8;
  localparam int PB = 4;
  localparam int DB = 24;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  always #5 clk = ~clk;

  led_pio_pwm #(.WIDTH(W), .PWM_BITS(PB), .DIV_BITS(DB), .BLINK_DIV_RST(24'd4_999_999)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // Model: register contents plus edge counts since reset (PWM) and since the last divider restart (blink).
  logic [W-1:0]  m_data, m_blink, m_out;
  logic [PB-1:0] m_duty;
  logic [DB-1:0] m_div;
  longint        n_pwm, m_blk;
  bit            m_valid = 0;
  int            vec = 0, errs = 0;

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2: return 32'(m_data);
      3'd3:             return 32'(m_blink);
      3'd4:             return 32'(m_duty);
      3'd5:             return 32'(m_div);
      default:          return 32'h0;
    endcase
  endfunction

  // Phase starts on and has flipped once per completed (div+1)-edge interval.
  function automatic bit m_phase();
    longint q;
    q = m_blk / (longint'(m_div) + 1);
    return (q % 2) == 0;
  endfunction

  function automatic bit m_pwm_on();
    longint pos;
    pos = n_pwm % (longint'(1) << PB);
    return (m_duty == {PB{1'b1}}) || (pos < longint'(m_duty));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit wr, input logic [2:0] a, input logic [31:0] d);
    bit ph, on;
    reset_n    = ~rst;
    write_n    = ~wr;
    chipselect = wr ? 1'b1 : 1'($urandom_range(0, 1));
    address    = a;
    writedata  = d;
    #1;
    if (m_valid) chk("readdata", readdata, m_read(a));
    if (rst) begin
      m_data = '0; m_blink = '0; m_duty = '1; m_div = 24'd4_999_999;
      m_out = '0; n_pwm = 0; m_blk = 0; m_valid = 1;
    end else begin
      ph = m_phase();
      on = m_pwm_on();
      m_out = m_data & (~m_blink | {W{ph}}) & {W{on}};
      n_pwm++;
      m_blk++;
      if (wr) begin
        case (a)
          3'd0: m_data  = d[W-1:0];
          3'd1: m_data  = m_data | d[W-1:0];
          3'd2: m_data  = m_data & ~d[W-1:0];
          3'd3: m_blink = d[W-1:0];
          3'd4: m_duty  = d[PB-1:0];
          3'd5: begin m_div = d[DB-1:0]; m_blk = 0; end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    if (m_valid) chk("out_port", 32'(out_port), 32'(m_out));
  endtask

  initial begin
    int cnt, guard, r;
    logic [2:0] ra;
    logic [31:0] rd;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int a = 0; a < 8; a++) step(0, 0, 3'(a), 0);
    step(0, 0, 3'd5, 0);
    chk("div_rst", readdata, 32'h004C_4B3F);
    step(0, 0, 3'd4, 0);
    chk("duty_rst", readdata, 32'h0000_000F);

    // Plain port behaviour
    step(0, 1, 3'd0, 32'hA5);
    step(0, 0, 3'd0, 0);
    chk("t1_rd", readdata, 32'hA5);
    chk("t1_out", 32'(out_port), 32'hA5);

    // Set / clear aliases
    step(0, 1, 3'd0, 32'hF0);
    step(0, 1, 3'd1, 32'h0F);
    step(0, 1, 3'd2, 32'hFFFF_FF81);
    for (int a = 0; a < 3; a++) begin
      step(0, 0, 3'(a), 0);
      chk("t2_rd", readdata, 32'h7E);
    end

    // Blink with divider 3: 4 on, 4 off
    step(0, 1, 3'd5, 32'd3);
    step(0, 1, 3'd3, 32'h01);
    step(0, 1, 3'd0, 32'h01);
    repeat (24) step(0, 0, 3'd3, 0);

    // PWM duty 4 of 16
    step(0, 1, 3'd3, 32'h0);
    step(0, 1, 3'd0, 32'hFF);
    step(0, 1, 3'd4, 32'd4);
    repeat (4) step(0, 0, 3'd4, 0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 3'd4, 0);
      if (out_port === 8'hFF) cnt++;
    end
    chk("t4_on_cnt", 32'(cnt), 32'd4);
    step(0, 1, 3'd4, 32'd0);
    repeat (18) step(0, 0, 3'd0, 0);
    step(0, 1, 3'd4, 32'd15);
    repeat (18) step(0, 0, 3'd0, 0);

    // Divider rewrite landing on the terminal count
    step(0, 1, 3'd5, 32'd5);
    step(0, 1, 3'd3, 32'hFF);
    step(0, 1, 3'd0, 32'hFF);
    guard = 0;
    while ((m_blk % 6) != 5 && guard < 20) begin
      step(0, 0, 3'd5, 0);
      guard++;
    end
    chk("t5_tc_reached", 32'(guard < 20), 32'd1);
    step(0, 1, 3'd5, 32'd5);
    repeat (6) step(0, 0, 3'd5, 0);
    chk("t5_phase_hold", 32'(out_port), 32'hFF);
    repeat (8) step(0, 0, 3'd5, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 99);
      ra = 3'($urandom_range(0, 7));
      rd = $urandom;
      if (ra == 3'd5) rd = 32'($urandom_range(0, 6));
      if (r < 2)       step(1, 0, ra, rd);
      else if (r < 40) step(0, 1, ra, rd);
      else             step(0, 0, ra, 0);
    end

    // Reset mid-blink / mid-PWM, reserved addresses
    step(0, 1, 3'd5, 32'd2);
    step(0, 1, 3'd3, 32'h0F);
    step(0, 1, 3'd4, 32'd9);
    step(0, 1, 3'd0, 32'hFF);
    repeat (5) step(0, 0, 3'd0, 0);
    step(1, 0, 3'd6, 0);
    chk("t6_out_rst", 32'(out_port), 32'h0);
    step(0, 1, 3'd6, 32'hFFFF_FFFF);
    step(0, 0, 3'd6, 0);
    chk("t6_rsv6", readdata, 32'h0);
    step(0, 0, 3'd0, 0);
    chk("t6_data_rst", readdata, 32'h0);
    step(0, 0, 3'd3, 0);
    chk("t6_blink_rst", readdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
